// File: rtl/evaluator_pkg.sv
// Board geometry, scoring weights and window-enumeration helpers for the
// connect-four move evaluator.
package evaluator_pkg;

    localparam int ROWS                   = 6;
    localparam int COLS                   = 7;
    localparam int FIELD_SIZE             = 42;
    localparam int COL_SIZE               = 3;
    localparam int PILED_COUNT_ARRAY_SIZE = 21;

    localparam int W_TWO      = 2;
    localparam int W_THREE    = 5;
    localparam int W_FOUR     = 100;
    localparam int W_CENTER   = 3;
    localparam int CENTER_COL = 3;

    typedef enum logic [1:0] {
        DIR_H,
        DIR_V,
        DIR_D,
        DIR_A
    } dir_t;

    function automatic int dir_dr(dir_t d);
        return (d == DIR_H) ? 0 : 1;
    endfunction

    function automatic int dir_dc(dir_t d);
        case (d)
            DIR_H:   return 1;
            DIR_V:   return 0;
            DIR_D:   return 1;
            default: return -1;
        endcase
    endfunction

    // A window is anchored at its bottom cell (r, c) and extends three steps along d.
    function automatic logic window_fits(int r, int c, dir_t d);
        int er;
        int ec;
        er = r + 3 * dir_dr(d);
        ec = c + 3 * dir_dc(d);
        return (er < ROWS) && (ec >= 0) && (ec < COLS);
    endfunction

    function automatic logic [5:0] cell_at(int r, int c, dir_t d, int k);
        int idx;
        idx = (r + k * dir_dr(d)) * COLS + c + k * dir_dc(d);
        return idx[5:0];
    endfunction

    function automatic int window_points(int nme, int nop);
        int pts;
        pts = 0;
        if (nop == 0) begin
            case (nme)
                2:       pts = W_TWO;
                3:       pts = W_THREE;
                4:       pts = W_FOUR;
                default: pts = 0;
            endcase
        end else if (nme == 0) begin
            case (nop)
                2:       pts = -W_TWO;
                3:       pts = -W_THREE;
                4:       pts = -W_FOUR;
                default: pts = 0;
            endcase
        end
        return pts;
    endfunction

    function automatic logic has_four(logic [FIELD_SIZE-1:0] f);
        logic found;
        logic full;
        found = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int d = 0; d < 4; d++) begin
                    if (window_fits(r, c, dir_t'(d[1:0]))) begin
                        full = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            if (!f[cell_at(r, c, dir_t'(d[1:0]), k)]) full = 1'b0;
                        end
                        if (full) found = 1'b1;
                    end
                end
            end
        end
        return found;
    endfunction

    function automatic logic signed [15:0] position_score(logic [FIELD_SIZE-1:0] me,
                                                          logic [FIELD_SIZE-1:0] op);
        int acc;
        int nme;
        int nop;
        logic [5:0] idx;
        acc = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int d = 0; d < 4; d++) begin
                    if (window_fits(r, c, dir_t'(d[1:0]))) begin
                        nme = 0;
                        nop = 0;
                        for (int k = 0; k < 4; k++) begin
                            idx = cell_at(r, c, dir_t'(d[1:0]), k);
                            if (me[idx]) nme++;
                            if (op[idx]) nop++;
                        end
                        acc = acc + window_points(nme, nop);
                    end
                end
            end
        end
        // Cells claimed by both sides are contested and do not earn the center bonus.
        for (int r = 0; r < ROWS; r++) begin
            if (me[r*COLS+CENTER_COL] && !op[r*COLS+CENTER_COL]) acc = acc + W_CENTER;
            if (op[r*COLS+CENTER_COL] && !me[r*COLS+CENTER_COL]) acc = acc - W_CENTER;
        end
        return acc[15:0];
    endfunction

endpackage

// File: rtl/evaluator_seq_checker.sv
// Four-in-a-row detector over one 42-cell field (all 69 windows).
module evaluator_seq_checker
    import evaluator_pkg::*;
(
    input  logic [FIELD_SIZE-1:0] i_field,
    output logic                  o_four
);

    assign o_four = has_four(i_field);

endmodule

// File: rtl/evaluator.sv
// Drops one stone into the chosen column, then registers the new position
// together with win flags and a heuristic score one clock later.
module evaluator
    import evaluator_pkg::*;
#(
    parameter bit IS_ME = 1'b1
) (
    input  logic                              w_clk,
    input  logic                              w_rst_n,
    input  logic                              w_en,
    input  logic [FIELD_SIZE-1:0]             i_me_field,
    input  logic [FIELD_SIZE-1:0]             i_op_field,
    input  logic [PILED_COUNT_ARRAY_SIZE-1:0] i_piled_array,
    input  logic [COL_SIZE-1:0]               i_col,
    output logic                              o_valid,
    output logic                              o_move_ok,
    output logic [FIELD_SIZE-1:0]             o_me_field,
    output logic [FIELD_SIZE-1:0]             o_op_field,
    output logic [PILED_COUNT_ARRAY_SIZE-1:0] o_piled_array,
    output logic                              o_me_win,
    output logic                              o_op_win,
    output logic signed [15:0]                o_score
);

    logic [COL_SIZE-1:0]               cur_cnt;
    logic                              move_ok;
    logic [FIELD_SIZE-1:0]             drop_mask;
    logic [FIELD_SIZE-1:0]             next_me;
    logic [FIELD_SIZE-1:0]             next_op;
    logic [PILED_COUNT_ARRAY_SIZE-1:0] next_piled;
    logic                              me_four;
    logic                              op_four;
    logic signed [15:0]                next_score;

    always_comb begin
        cur_cnt    = '0;
        drop_mask  = '0;
        next_piled = i_piled_array;
        next_me    = i_me_field;
        next_op    = i_op_field;
        for (int c = 0; c < COLS; c++) begin
            if (i_col == 3'(c)) cur_cnt = i_piled_array[c*COL_SIZE +: COL_SIZE];
        end
        move_ok = (i_col < 3'(COLS)) && (cur_cnt < 3'(ROWS));
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (i_col == 3'(c) && cur_cnt == 3'(r)) drop_mask[r*COLS+c] = 1'b1;
            end
        end
        if (move_ok) begin
            for (int c = 0; c < COLS; c++) begin
                if (i_col == 3'(c)) next_piled[c*COL_SIZE +: COL_SIZE] = cur_cnt + 3'd1;
            end
            if (IS_ME) next_me = i_me_field | drop_mask;
            else       next_op = i_op_field | drop_mask;
        end
    end

    evaluator_seq_checker u_me_checker (
        .i_field (next_me),
        .o_four  (me_four)
    );

    evaluator_seq_checker u_op_checker (
        .i_field (next_op),
        .o_four  (op_four)
    );

    assign next_score = position_score(next_me, next_op);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            o_valid       <= 1'b0;
            o_move_ok     <= 1'b0;
            o_me_field    <= '0;
            o_op_field    <= '0;
            o_piled_array <= '0;
            o_me_win      <= 1'b0;
            o_op_win      <= 1'b0;
            o_score       <= '0;
        end else begin
            o_valid <= w_en;
            if (w_en) begin
                o_move_ok     <= move_ok;
                o_me_field    <= next_me;
                o_op_field    <= next_op;
                o_piled_array <= next_piled;
                o_me_win      <= me_four;
                o_op_win      <= op_four;
                o_score       <= next_score;
            end
        end
    end

endmodule

// File: tb/tb_evaluator.sv
// Bench for the move evaluator: directed table, multi-cycle sequences and
// randomized requests against a board-level reference model.
module tb_evaluator;

    logic        w_clk = 1'b0;
    logic        w_rst_n;
    logic        w_en;
    logic [41:0] i_me_field;
    logic [41:0] i_op_field;
    logic [20:0] i_piled_array;
    logic [2:0]  i_col;

    logic        a_valid, a_ok, a_mw, a_ow;
    logic [41:0] a_me, a_op;
    logic [20:0] a_piled;
    logic signed [15:0] a_score;
    logic        b_valid, b_ok, b_mw, b_ow;
    logic [41:0] b_me, b_op;
    logic [20:0] b_piled;
    logic signed [15:0] b_score;

    always #5 w_clk = ~w_clk;

    evaluator #(.IS_ME(1'b1)) dut_me (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_en(w_en),
        .i_me_field(i_me_field), .i_op_field(i_op_field),
        .i_piled_array(i_piled_array), .i_col(i_col),
        .o_valid(a_valid), .o_move_ok(a_ok), .o_me_field(a_me), .o_op_field(a_op),
        .o_piled_array(a_piled), .o_me_win(a_mw), .o_op_win(a_ow), .o_score(a_score)
    );

    evaluator #(.IS_ME(1'b0)) dut_op (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_en(w_en),
        .i_me_field(i_me_field), .i_op_field(i_op_field),
        .i_piled_array(i_piled_array), .i_col(i_col),
        .o_valid(b_valid), .o_move_ok(b_ok), .o_me_field(b_me), .o_op_field(b_op),
        .o_piled_array(b_piled), .o_me_win(b_mw), .o_op_win(b_ow), .o_score(b_score)
    );

    typedef struct {
        logic [41:0] me;
        logic [41:0] op;
        logic [20:0] piles;
        bit          ok;
        bit          mw;
        bit          ow;
        int          score;
    } res_t;

    typedef struct {
        logic [41:0] me;
        logic [41:0] op;
        logic [20:0] piles;
        int          col;
        bit          is_me;
        bit          exp_ok;
        bit          exp_mw;
        bit          exp_ow;
        int          exp_score;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    res_t last_a;
    res_t last_b;

    function automatic res_t zero_res();
        res_t z;
        z.me = '0; z.op = '0; z.piles = '0;
        z.ok = 0; z.mw = 0; z.ow = 0; z.score = 0;
        return z;
    endfunction

    // Reference: apply gravity on a 6x7 grid, then walk every line of four.
    function automatic res_t model(logic [41:0] me, logic [41:0] op,
                                   logic [20:0] piles, int col, bit is_me);
        res_t r;
        bit   m[6][7];
        bit   o[6][7];
        int   h, nm, no, rr, cc;
        int   dr[4] = '{0, 1, 1, 1};
        int   dc[4] = '{1, 0, 1, -1};
        r = zero_res();
        r.me = me; r.op = op; r.piles = piles;
        if (col <= 6) begin
            h = int'(piles[3*col +: 3]);
            if (h < 6) begin
                if (is_me) r.me[h*7+col] = 1'b1;
                else       r.op[h*7+col] = 1'b1;
                r.piles[3*col +: 3] = 3'(h + 1);
                r.ok = 1;
            end
        end
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 7; x++) begin
                m[y][x] = r.me[y*7+x];
                o[y][x] = r.op[y*7+x];
            end
        for (int d = 0; d < 4; d++)
            for (int y = 0; y < 6; y++)
                for (int x = 0; x < 7; x++) begin
                    rr = y + 3*dr[d];
                    cc = x + 3*dc[d];
                    if (rr < 6 && cc >= 0 && cc < 7) begin
                        nm = 0; no = 0;
                        for (int k = 0; k < 4; k++) begin
                            nm += int'(m[y+k*dr[d]][x+k*dc[d]]);
                            no += int'(o[y+k*dr[d]][x+k*dc[d]]);
                        end
                        if (nm == 4) r.mw = 1;
                        if (no == 4) r.ow = 1;
                        if (no == 0) r.score += (nm == 2) ? 2 : (nm == 3) ? 5 : (nm == 4) ? 100 : 0;
                        if (nm == 0) r.score -= (no == 2) ? 2 : (no == 3) ? 5 : (no == 4) ? 100 : 0;
                    end
                end
        for (int y = 0; y < 6; y++) begin
            if (m[y][3] && !o[y][3]) r.score += 3;
            if (o[y][3] && !m[y][3]) r.score -= 3;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_dut(input bit is_me, input res_t e, input bit v, input string tag);
        if (is_me) begin
            chk({tag, ".a.valid"}, 64'(a_valid), 64'(v));
            chk({tag, ".a.ok"},    64'(a_ok),    64'(e.ok));
            chk({tag, ".a.me"},    64'(a_me),    64'(e.me));
            chk({tag, ".a.op"},    64'(a_op),    64'(e.op));
            chk({tag, ".a.piles"}, 64'(a_piled), 64'(e.piles));
            chk({tag, ".a.mwin"},  64'(a_mw),    64'(e.mw));
            chk({tag, ".a.owin"},  64'(a_ow),    64'(e.ow));
            chk({tag, ".a.score"}, 64'(a_score), 64'(16'(e.score)));
        end else begin
            chk({tag, ".b.valid"}, 64'(b_valid), 64'(v));
            chk({tag, ".b.ok"},    64'(b_ok),    64'(e.ok));
            chk({tag, ".b.me"},    64'(b_me),    64'(e.me));
            chk({tag, ".b.op"},    64'(b_op),    64'(e.op));
            chk({tag, ".b.piles"}, 64'(b_piled), 64'(e.piles));
            chk({tag, ".b.mwin"},  64'(b_mw),    64'(e.mw));
            chk({tag, ".b.owin"},  64'(b_ow),    64'(e.ow));
            chk({tag, ".b.score"}, 64'(b_score), 64'(16'(e.score)));
        end
    endtask

    // One clock: present inputs, clock them, check both instances #1 later.
    task automatic step(input logic [41:0] me, input logic [41:0] op,
                        input logic [20:0] piles, input int col, input bit en,
                        input string tag);
        res_t ea, eb;
        i_me_field = me; i_op_field = op; i_piled_array = piles;
        i_col = 3'(col); w_en = en;
        ea = model(me, op, piles, col, 1'b1);
        eb = model(me, op, piles, col, 1'b0);
        @(posedge w_clk);
        #1;
        if (en) begin
            last_a = ea;
            last_b = eb;
        end
        check_dut(1'b1, last_a, en, tag);
        check_dut(1'b0, last_b, en, tag);
    endtask

    vec_t vecs[8];

    initial begin
        w_rst_n = 1'b0; w_en = 1'b0;
        i_me_field = '0; i_op_field = '0; i_piled_array = '0; i_col = '0;
        last_a = zero_res();
        last_b = zero_res();

        vecs[0] = '{42'h0, 42'h0, 21'h0, 3, 1, 1, 0, 0, 3};
        vecs[1] = '{42'h0, 42'h0, 21'h0, 3, 0, 1, 0, 0, -3};
        vecs[2] = '{42'h7, 42'h0, 21'd73, 3, 1, 1, 1, 0, 110};
        vecs[3] = '{42'h0, 42'h4081, 21'd3, 0, 0, 1, 0, 1, -107};
        vecs[4] = '{42'h0, 42'h0, 21'h30000, 5, 1, 0, 0, 0, 0};
        vecs[5] = '{42'h8, 42'h0, 21'h200, 7, 1, 0, 0, 0, 3};
        vecs[6] = '{42'h8, 42'h8, 21'h200, 0, 1, 1, 0, 0, 0};
        vecs[7] = '{42'h8, 42'h0, 21'h200, 7, 0, 0, 0, 0, 3};

        #12;
        check_dut(1'b1, zero_res(), 1'b0, "reset");
        check_dut(1'b0, zero_res(), 1'b0, "reset");
        @(negedge w_clk);
        w_rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].me, vecs[i].op, vecs[i].piles, vecs[i].col, 1'b1, $sformatf("vec%0d", i));
            if (vecs[i].is_me) begin
                chk($sformatf("vec%0d.tbl.ok", i),    64'(a_ok),    64'(vecs[i].exp_ok));
                chk($sformatf("vec%0d.tbl.mwin", i),  64'(a_mw),    64'(vecs[i].exp_mw));
                chk($sformatf("vec%0d.tbl.owin", i),  64'(a_ow),    64'(vecs[i].exp_ow));
                chk($sformatf("vec%0d.tbl.score", i), 64'(a_score), 64'(16'(vecs[i].exp_score)));
            end else begin
                chk($sformatf("vec%0d.tbl.ok", i),    64'(b_ok),    64'(vecs[i].exp_ok));
                chk($sformatf("vec%0d.tbl.mwin", i),  64'(b_mw),    64'(vecs[i].exp_mw));
                chk($sformatf("vec%0d.tbl.owin", i),  64'(b_ow),    64'(vecs[i].exp_ow));
                chk($sformatf("vec%0d.tbl.score", i), 64'(b_score), 64'(16'(vecs[i].exp_score)));
            end
        end

        // Back-to-back requests, then idle cycles hold data and drop o_valid.
        step(42'h0, 42'h0, 21'h0, 1, 1'b1, "b2b0");
        step(42'h0, 42'h0, 21'h0, 4, 1'b1, "b2b1");
        step(42'h0, 42'h0, 21'h0, 6, 1'b1, "b2b2");
        step(42'h3, 42'h0, 21'h9, 2, 1'b0, "hold0");
        step(42'h3, 42'h0, 21'h9, 5, 1'b0, "hold1");

        for (int n = 0; n < 300; n++) begin
            logic [41:0] rm, ro;
            logic [20:0] rp;
            rm = 42'({$urandom(), $urandom()} & {$urandom(), $urandom()});
            ro = 42'({$urandom(), $urandom()} & {$urandom(), $urandom()});
            if ($urandom_range(0, 3) != 0) ro = ro & ~rm;
            for (int c = 0; c < 7; c++)
                rp[3*c +: 3] = ($urandom_range(0, 4) == 0) ? 3'd6 : 3'($urandom_range(0, 6));
            step(rm, ro, rp, int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                 $sformatf("rnd%0d", n));
        end

        // Reset between the request edge and the following edge.
        step(42'h7, 42'h0, 21'd73, 3, 1'b1, "prerst");
        #2;
        w_rst_n = 1'b0;
        #1;
        last_a = zero_res();
        last_b = zero_res();
        check_dut(1'b1, last_a, 1'b0, "midrst");
        check_dut(1'b0, last_b, 1'b0, "midrst");
        w_en = 1'b0;
        @(posedge w_clk);
        #1;
        w_rst_n = 1'b1;
        @(posedge w_clk);
        #1;
        check_dut(1'b1, last_a, 1'b0, "postrst");
        check_dut(1'b0, last_b, 1'b0, "postrst");
        step(42'h0, 42'h0, 21'h0, 3, 1'b1, "recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
